// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-memory interface: access size codes,
// request direction and the bus-master FSM state encoding.
package msrv32_pkg;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } dmem_state_t;

  // Byte accesses never fault; halves need an even address, words a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      LS_BYTE: bad = 1'b0;
      LS_HALF: bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Combinational lane select and sign/zero extension of a 32-bit memory read
// word into a load result.
module msrv32_load_align
  import msrv32_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed lane, then widen it to 32 bits.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (addr_lo)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      LS_BYTE: data = {{24{~zero_ext & byte_s[7]}}, byte_s};
      LS_HALF: data = {{16{~zero_ext & half_s[15]}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_if.sv
// Data-memory bus master: captures a load/store, holds a request until memory
// is ready or the access times out, and stalls the pipeline meanwhile.
module msrv32_dmem_if
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid_in,
  input  logic        req_wr_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ready_in,
  output logic [31:0] mem_addr_out,
  output logic        mem_rd_req_out,
  output logic        mem_wr_req_out,
  output logic [31:0] mem_wdata_out,
  output logic [3:0]  mem_wr_mask_out,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  dmem_state_t state_r;
  logic [7:0]  cnt_r;
  logic        dir_r;
  logic [1:0]  ld_addr_lo_r;
  logic [1:0]  ld_size_r;
  logic        ld_zero_ext_r;

  logic        misaligned_s;
  logic        accept_s;
  logic        timeout_s;
  logic [3:0]  mask_s;
  logic [31:0] wdata_s;
  logic [31:0] align_s;

  // Request qualification, store lane mask and replicated store data.
  always_comb begin
    misaligned_s = is_misaligned(load_size_in, iadder_in[1:0]);
    accept_s     = (state_r == ST_IDLE) && req_valid_in && !misaligned_s;
    timeout_s    = (state_r == ST_ACCESS) && !mem_ready_in && (cnt_r == TO_LAST);
    mask_s       = 4'b0000;
    wdata_s      = 32'h0000_0000;
    case (load_size_in)
      LS_BYTE: begin
        mask_s  = 4'b0001 << iadder_in[1:0];
        wdata_s = {4{rs2_in[7:0]}};
      end
      LS_HALF: begin
        mask_s  = 4'b0011 << iadder_in[1:0];
        wdata_s = {2{rs2_in[15:0]}};
      end
      default: begin
        mask_s  = 4'b1111;
        wdata_s = rs2_in;
      end
    endcase
  end

  // Ready or timeout in the final access cycle releases the pipeline.
  assign stall_out = accept_s || ((state_r == ST_ACCESS) && !mem_ready_in && !timeout_s);

  msrv32_load_align u_align (
    .rdata    (mem_rdata_in),
    .addr_lo  (ld_addr_lo_r),
    .size     (ld_size_r),
    .zero_ext (ld_zero_ext_r),
    .data     (align_s)
  );

  // Bus-master FSM with all registered outputs.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      dir_r           <= DIR_LOAD;
      ld_addr_lo_r    <= 2'b00;
      ld_size_r       <= LS_BYTE;
      ld_zero_ext_r   <= 1'b0;
      mem_addr_out    <= 32'h0000_0000;
      mem_rd_req_out  <= 1'b0;
      mem_wr_req_out  <= 1'b0;
      mem_wdata_out   <= 32'h0000_0000;
      mem_wr_mask_out <= 4'b0000;
      load_data_out   <= 32'h0000_0000;
      load_valid_out  <= 1'b0;
      misaligned_out  <= 1'b0;
      bus_error_out   <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      misaligned_out <= 1'b0;
      bus_error_out  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid_in && misaligned_s) begin
            misaligned_out <= 1'b1;
          end else if (accept_s) begin
            state_r        <= ST_ACCESS;
            cnt_r          <= 8'd0;
            dir_r          <= req_wr_in;
            ld_addr_lo_r   <= iadder_in[1:0];
            ld_size_r      <= load_size_in;
            ld_zero_ext_r  <= load_unsigned_in;
            mem_addr_out   <= {iadder_in[31:2], 2'b00};
            mem_rd_req_out <= (req_wr_in == DIR_LOAD);
            mem_wr_req_out <= (req_wr_in == DIR_STORE);
            if (req_wr_in == DIR_STORE) begin
              mem_wdata_out   <= wdata_s;
              mem_wr_mask_out <= mask_s;
            end else begin
              mem_wdata_out   <= 32'h0000_0000;
              mem_wr_mask_out <= 4'b0000;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (mem_ready_in) begin
            state_r        <= ST_IDLE;
            mem_rd_req_out <= 1'b0;
            mem_wr_req_out <= 1'b0;
            if (dir_r == DIR_LOAD) begin
              load_data_out  <= align_s;
              load_valid_out <= 1'b1;
            end else begin
              load_valid_out <= 1'b0;
            end
          end else if (cnt_r == TO_LAST) begin
            state_r        <= ST_IDLE;
            mem_rd_req_out <= 1'b0;
            mem_wr_req_out <= 1'b0;
            load_data_out  <= 32'h0000_0000;
            bus_error_out  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          mem_rd_req_out <= 1'b0;
          mem_wr_req_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_if.sv
// Directed self-checking bench for msrv32_dmem_if: loads, stores, misalignment,
// timeout, ready-in-final-cycle and asynchronous reset during an access.
module tb_msrv32_dmem_if;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_valid_in;
  logic        req_wr_in;
  logic [31:0] iadder_in;
  logic [31:0] rs2_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] mem_rdata_in;
  logic        mem_ready_in;
  logic [31:0] mem_addr_out;
  logic        mem_rd_req_out;
  logic        mem_wr_req_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wr_mask_out;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        misaligned_out;
  logic        bus_error_out;

  int n_checks = 0;
  int n_errors = 0;

  msrv32_dmem_if #(.TIMEOUT_CYCLES(15)) dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .req_valid_in     (req_valid_in),
    .req_wr_in        (req_wr_in),
    .iadder_in        (iadder_in),
    .rs2_in           (rs2_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .mem_rdata_in     (mem_rdata_in),
    .mem_ready_in     (mem_ready_in),
    .mem_addr_out     (mem_addr_out),
    .mem_rd_req_out   (mem_rd_req_out),
    .mem_wr_req_out   (mem_wr_req_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_wr_mask_out  (mem_wr_mask_out),
    .stall_out        (stall_out),
    .load_data_out    (load_data_out),
    .load_valid_out   (load_valid_out),
    .misaligned_out   (misaligned_out),
    .bus_error_out    (bus_error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  // Minimum-latency load: request in N, ready in N+1, result checked in N+2.
  task automatic load_once(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic zext, input logic [31:0] rdata, input logic [31:0] exp);
    req_valid_in = 1'b1; req_wr_in = 1'b0; iadder_in = addr;
    load_size_in = size; load_unsigned_in = zext; mem_ready_in = 1'b0;
    @(negedge clk_in);
    check({tag, "_stall_req"}, 32'(stall_out), 32'd1);
    next_cycle();
    req_valid_in = 1'b0; mem_ready_in = 1'b1; mem_rdata_in = rdata;
    @(negedge clk_in);
    check({tag, "_rd_req"}, 32'(mem_rd_req_out), 32'd1);
    check({tag, "_addr"}, mem_addr_out, {addr[31:2], 2'b00});
    check({tag, "_stall_rdy"}, 32'(stall_out), 32'd0);
    next_cycle();
    mem_ready_in = 1'b0; mem_rdata_in = 32'h0000_0000;
    @(negedge clk_in);
    check({tag, "_valid"}, 32'(load_valid_out), 32'd1);
    check({tag, "_data"}, load_data_out, exp);
    check({tag, "_rd_drop"}, 32'(mem_rd_req_out), 32'd0);
    next_cycle();
  endtask

  // Store with 'waits' ready-less cycles before completion.
  task automatic store_once(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, input logic [3:0] exp_mask,
                            input logic [31:0] exp_wdata, input int waits);
    req_valid_in = 1'b1; req_wr_in = 1'b1; iadder_in = addr;
    load_size_in = size; rs2_in = data; mem_ready_in = 1'b0;
    next_cycle();
    req_valid_in = 1'b0; rs2_in = 32'h0000_0000;
    for (int w = 0; w < waits; w++) begin
      @(negedge clk_in);
      check({tag, "_hold_wr"}, 32'(mem_wr_req_out), 32'd1);
      check({tag, "_hold_stall"}, 32'(stall_out), 32'd1);
      check({tag, "_hold_mask"}, 32'(mem_wr_mask_out), 32'(exp_mask));
      next_cycle();
    end
    mem_ready_in = 1'b1;
    @(negedge clk_in);
    check({tag, "_wr_req"}, 32'(mem_wr_req_out), 32'd1);
    check({tag, "_rd_req"}, 32'(mem_rd_req_out), 32'd0);
    check({tag, "_mask"}, 32'(mem_wr_mask_out), 32'(exp_mask));
    check({tag, "_wdata"}, mem_wdata_out, exp_wdata);
    check({tag, "_addr"}, mem_addr_out, {addr[31:2], 2'b00});
    next_cycle();
    mem_ready_in = 1'b0;
    @(negedge clk_in);
    check({tag, "_no_valid"}, 32'(load_valid_out), 32'd0);
    check({tag, "_wr_drop"}, 32'(mem_wr_req_out), 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1; req_valid_in = 1'b0; req_wr_in = 1'b0; iadder_in = 32'h0;
    rs2_in = 32'h0; load_size_in = 2'b00; load_unsigned_in = 1'b0;
    mem_rdata_in = 32'h0; mem_ready_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_addr", mem_addr_out, 32'h0);
    check("rst_req", {30'd0, mem_rd_req_out, mem_wr_req_out}, 32'd0);
    check("rst_pulses", {29'd0, load_valid_out, misaligned_out, bus_error_out}, 32'd0);
    check("rst_data", load_data_out, 32'h0);
    check("rst_stall", 32'(stall_out), 32'd0);
    next_cycle();
    reset_in = 1'b0;
    next_cycle();

    load_once("ldw", 32'h0000_1000, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    load_once("lb_s", 32'h0000_1003, 2'b00, 1'b0, 32'h8012_3456, 32'hFFFF_FF80);
    load_once("lb_u", 32'h0000_1003, 2'b00, 1'b1, 32'h8012_3456, 32'h0000_0080);
    load_once("lb_lane1", 32'h0000_1001, 2'b00, 1'b0, 32'h0000_7F00, 32'h0000_007F);
    load_once("lh_s", 32'h0000_1002, 2'b01, 1'b0, 32'h8001_1234, 32'hFFFF_8001);
    load_once("lh_u", 32'h0000_1000, 2'b01, 1'b1, 32'h1234_9ABC, 32'h0000_9ABC);
    load_once("ld_sz3", 32'h0000_1004, 2'b11, 1'b0, 32'h8765_4321, 32'h8765_4321);

    store_once("sh_hi", 32'h0000_2002, 2'b01, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 0);
    store_once("sh_lo", 32'h0000_2000, 2'b01, 32'hFFFF_1234, 4'b0011, 32'h1234_1234, 0);
    store_once("sb", 32'h0000_2001, 2'b00, 32'h1234_56A5, 4'b0010, 32'hA5A5_A5A5, 2);
    store_once("sw", 32'h0000_2008, 2'b10, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0);

    // Misaligned word followed immediately by an aligned load.
    req_valid_in = 1'b1; req_wr_in = 1'b0; iadder_in = 32'h0000_3001; load_size_in = 2'b10;
    @(negedge clk_in);
    check("mis_stall", 32'(stall_out), 32'd0);
    next_cycle();
    iadder_in = 32'h0000_3004;
    @(negedge clk_in);
    check("mis_pulse", 32'(misaligned_out), 32'd1);
    check("mis_no_req", 32'(mem_rd_req_out), 32'd0);
    check("mis_next_stall", 32'(stall_out), 32'd1);
    next_cycle();
    req_valid_in = 1'b0; mem_ready_in = 1'b1; mem_rdata_in = 32'h1234_5678;
    @(negedge clk_in);
    check("mis_next_rd", 32'(mem_rd_req_out), 32'd1);
    check("mis_next_addr", mem_addr_out, 32'h0000_3004);
    check("mis_pulse_end", 32'(misaligned_out), 32'd0);
    next_cycle();
    mem_ready_in = 1'b0;
    @(negedge clk_in);
    check("mis_next_valid", 32'(load_valid_out), 32'd1);
    check("mis_next_data", load_data_out, 32'h1234_5678);
    next_cycle();

    // Misaligned half.
    req_valid_in = 1'b1; iadder_in = 32'h0000_3003; load_size_in = 2'b01;
    next_cycle();
    req_valid_in = 1'b0;
    @(negedge clk_in);
    check("mis_half", 32'(misaligned_out), 32'd1);
    next_cycle();

    // Back-to-back: second request in the IDLE cycle right after completion.
    req_valid_in = 1'b1; req_wr_in = 1'b0; iadder_in = 32'h0000_7000; load_size_in = 2'b10;
    next_cycle();
    req_valid_in = 1'b0; mem_ready_in = 1'b1; mem_rdata_in = 32'hAAAA_0001;
    next_cycle();
    req_valid_in = 1'b1; iadder_in = 32'h0000_7004; mem_ready_in = 1'b0;
    @(negedge clk_in);
    check("b2b_valid1", 32'(load_valid_out), 32'd1);
    check("b2b_data1", load_data_out, 32'hAAAA_0001);
    check("b2b_stall", 32'(stall_out), 32'd1);
    next_cycle();
    req_valid_in = 1'b0; mem_ready_in = 1'b1; mem_rdata_in = 32'hBBBB_0002;
    @(negedge clk_in);
    check("b2b_addr2", mem_addr_out, 32'h0000_7004);
    check("b2b_rd2", 32'(mem_rd_req_out), 32'd1);
    next_cycle();
    mem_ready_in = 1'b0;
    @(negedge clk_in);
    check("b2b_data2", load_data_out, 32'hBBBB_0002);
    next_cycle();

    // Timeout: ready never arrives.
    req_valid_in = 1'b1; req_wr_in = 1'b0; iadder_in = 32'h0000_4000; load_size_in = 2'b10;
    next_cycle();
    req_valid_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk_in);
      check("to_rd_req", 32'(mem_rd_req_out), 32'd1);
      check("to_stall", 32'(stall_out), (i < 15) ? 32'd1 : 32'd0);
      check("to_no_err", 32'(bus_error_out), 32'd0);
      next_cycle();
    end
    @(negedge clk_in);
    check("to_err", 32'(bus_error_out), 32'd1);
    check("to_rd_drop", 32'(mem_rd_req_out), 32'd0);
    check("to_data", load_data_out, 32'h0);
    check("to_no_valid", 32'(load_valid_out), 32'd0);
    check("to_stall_low", 32'(stall_out), 32'd0);
    next_cycle();
    @(negedge clk_in);
    check("to_err_pulse", 32'(bus_error_out), 32'd0);
    next_cycle();

    // Ready arriving in the final timeout cycle wins.
    req_valid_in = 1'b1; iadder_in = 32'h0000_4100;
    next_cycle();
    req_valid_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        mem_ready_in = 1'b1; mem_rdata_in = 32'hCAFE_F00D;
      end
      @(negedge clk_in);
      check("tw_rd_req", 32'(mem_rd_req_out), 32'd1);
      next_cycle();
    end
    mem_ready_in = 1'b0;
    @(negedge clk_in);
    check("tw_no_err", 32'(bus_error_out), 32'd0);
    check("tw_valid", 32'(load_valid_out), 32'd1);
    check("tw_data", load_data_out, 32'hCAFE_F00D);
    next_cycle();

    // Asynchronous reset in the middle of an access.
    req_valid_in = 1'b1; iadder_in = 32'h0000_5000; load_size_in = 2'b10;
    next_cycle();
    req_valid_in = 1'b0;
    @(negedge clk_in);
    check("rs_rd_before", 32'(mem_rd_req_out), 32'd1);
    #1 reset_in = 1'b1;
    #1;
    check("rs_rd", 32'(mem_rd_req_out), 32'd0);
    check("rs_addr", mem_addr_out, 32'h0);
    check("rs_data", load_data_out, 32'h0);
    check("rs_stall", 32'(stall_out), 32'd0);
    check("rs_err", 32'(bus_error_out), 32'd0);
    next_cycle();
    reset_in = 1'b0;
    next_cycle();
    load_once("post_rst", 32'h0000_6000, 2'b10, 1'b0, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
